// File: rtl/fetch_buffer_stage_if.sv
// Signal bundle for fetch_buffer_stage: upstream PC offer, instruction-memory port and
// downstream result port. The stage binds the slave modport; the environment drives master.
interface fetch_buffer_stage_if #(
    parameter int ADDR_WIDTH        = 32,
    parameter int INSTRUCTION_WIDTH = 32
);
    // Handshakes: a transfer happens on a rising clk edge where the offering side's
    // valid (prev_done upstream, done_next downstream) is high and the taking side's
    // stall (stall_prev, next_stall) is low; an offered payload is held until it transfers.
    logic                         flush;
    logic                         prev_done;
    logic                         stall_prev;
    logic                         done_next;
    logic                         next_stall;
    logic [ADDR_WIDTH-1:0]        program_count_in;
    logic                         program_count_valid_in;
    logic [ADDR_WIDTH-1:0]        instruction_addr;
    logic                         instruction_fetch_activate;
    logic [INSTRUCTION_WIDTH-1:0] instruction_data;
    logic                         instruction_fetch_done;
    logic                         instruction_fetch_error;
    logic [ADDR_WIDTH-1:0]        program_count_out;
    logic                         program_count_valid_out;
    logic [INSTRUCTION_WIDTH-1:0] instruction_data_out;
    logic                         instruction_data_valid_out;
    logic                         instruction_fault_out;

    modport slave (
        input  flush, prev_done, next_stall, program_count_in, program_count_valid_in,
               instruction_data, instruction_fetch_done, instruction_fetch_error,
        output stall_prev, done_next, instruction_addr, instruction_fetch_activate,
               program_count_out, program_count_valid_out, instruction_data_out,
               instruction_data_valid_out, instruction_fault_out
    );

    modport master (
        output flush, prev_done, next_stall, program_count_in, program_count_valid_in,
               instruction_data, instruction_fetch_done, instruction_fetch_error,
        input  stall_prev, done_next, instruction_addr, instruction_fetch_activate,
               program_count_out, program_count_valid_out, instruction_data_out,
               instruction_data_valid_out, instruction_fault_out
    );
endinterface

// File: rtl/fetch_buffer_stage.sv
// Instruction-fetch stage: one outstanding memory fetch per accepted PC, results and
// invalid-PC bubbles queued in a small FIFO so downstream stalls never force a refetch.
module fetch_buffer_stage #(
    parameter int ADDR_WIDTH        = 32,
    parameter int INSTRUCTION_WIDTH = 32,
    parameter int BUF_DEPTH         = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    fetch_buffer_stage_if.slave            bus,
    output logic [1:0]                     dbg_state,
    output logic [$clog2(BUF_DEPTH+1)-1:0] dbg_count
);
    localparam int CW = $clog2(BUF_DEPTH + 1);
    localparam int PW = $clog2(BUF_DEPTH);
    localparam logic [CW:0] DEPTH_W = BUF_DEPTH[CW:0];

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
    logic [CW-1:0]          count_q, count_d;
    logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]          rd_ptr_q, rd_ptr_d;

    logic [ADDR_WIDTH-1:0]        fifo_pc_q       [BUF_DEPTH];
    logic [ADDR_WIDTH-1:0]        fifo_pc_d       [BUF_DEPTH];
    logic                         fifo_pc_valid_q [BUF_DEPTH];
    logic                         fifo_pc_valid_d [BUF_DEPTH];
    logic [INSTRUCTION_WIDTH-1:0] fifo_instr_q    [BUF_DEPTH];
    logic [INSTRUCTION_WIDTH-1:0] fifo_instr_d    [BUF_DEPTH];
    logic                         fifo_fault_q    [BUF_DEPTH];
    logic                         fifo_fault_d    [BUF_DEPTH];

    logic          fetch_done;
    logic          head_valid;
    logic          done_next_w;
    logic          pop;
    logic [CW:0]   count_after_pop;
    logic          idle_room;
    logic          req_room;
    logic          accept_allowed;
    logic          transfer_prev;
    logic          accept_fetch;
    logic          accept_bubble;
    logic          resp_push;
    logic          activate;
    logic [PW-1:0] bubble_slot;
    logic [CW-1:0] push_n;
    logic [CW-1:0] pop_n;

    // Accept/pop decisions. In REQ a new PC may only enter on the cycle the current
    // response lands, and only if the slot that response takes still leaves room.
    always_comb begin
        fetch_done      = bus.instruction_fetch_done && (state_q != ST_IDLE);
        head_valid      = !rst && (count_q != '0);
        done_next_w     = head_valid && !bus.flush;
        pop             = done_next_w && !bus.next_stall;
        count_after_pop = {1'b0, count_q} - {{CW{1'b0}}, pop};
        idle_room       = count_after_pop < DEPTH_W;
        req_room        = (count_after_pop + {{CW{1'b0}}, 1'b1}) < DEPTH_W;
        accept_allowed  = !rst && !bus.flush &&
                          (((state_q == ST_IDLE) && idle_room) ||
                           ((state_q == ST_REQ) && fetch_done && req_room));
        transfer_prev   = bus.prev_done && accept_allowed;
        accept_fetch    = transfer_prev && bus.program_count_valid_in;
        accept_bubble   = transfer_prev && !bus.program_count_valid_in;
        resp_push       = !rst && !bus.flush && (state_q == ST_REQ) && fetch_done;
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_fetch) begin
                    state_d = ST_REQ;
                    pc_d    = bus.program_count_in;
                end
            end
            ST_REQ: begin
                if (bus.flush) begin
                    state_d = fetch_done ? ST_IDLE : ST_DRAIN;
                end else if (fetch_done) begin
                    if (accept_fetch) begin
                        pc_d = bus.program_count_in;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_DRAIN: begin
                if (fetch_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A response and a bubble can land together; the response is older so it goes first.
    always_comb begin
        fifo_pc_d       = fifo_pc_q;
        fifo_pc_valid_d = fifo_pc_valid_q;
        fifo_instr_d    = fifo_instr_q;
        fifo_fault_d    = fifo_fault_q;
        bubble_slot     = resp_push ? (wr_ptr_q + PW'(1)) : wr_ptr_q;
        push_n          = {{(CW-1){1'b0}}, resp_push} + {{(CW-1){1'b0}}, accept_bubble};
        pop_n           = {{(CW-1){1'b0}}, pop};

        if (resp_push) begin
            fifo_pc_d[wr_ptr_q]       = pc_q;
            fifo_pc_valid_d[wr_ptr_q] = 1'b1;
            fifo_instr_d[wr_ptr_q]    = bus.instruction_fetch_error ? '0 : bus.instruction_data;
            fifo_fault_d[wr_ptr_q]    = bus.instruction_fetch_error;
        end
        if (accept_bubble) begin
            fifo_pc_d[bubble_slot]       = bus.program_count_in;
            fifo_pc_valid_d[bubble_slot] = 1'b0;
            fifo_instr_d[bubble_slot]    = '0;
            fifo_fault_d[bubble_slot]    = 1'b0;
        end

        if (bus.flush) begin
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            count_d  = count_q + push_n - pop_n;
            wr_ptr_d = wr_ptr_q + PW'(push_n);
            rd_ptr_d = rd_ptr_q + PW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            pc_q     <= '0;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
        fifo_pc_q       <= fifo_pc_d;
        fifo_pc_valid_q <= fifo_pc_valid_d;
        fifo_instr_q    <= fifo_instr_d;
        fifo_fault_q    <= fifo_fault_d;
    end

    // Storage is not reset, so every head field is masked while the FIFO is empty.
    always_comb begin
        activate                       = !rst && (state_q != ST_IDLE);
        bus.stall_prev                 = !accept_allowed;
        bus.done_next                  = done_next_w;
        bus.instruction_fetch_activate = activate;
        bus.instruction_addr           = activate ? pc_q : '0;
        bus.program_count_out          = head_valid ? fifo_pc_q[rd_ptr_q] : '0;
        bus.program_count_valid_out    = head_valid && fifo_pc_valid_q[rd_ptr_q];
        bus.instruction_data_out       = head_valid ? fifo_instr_q[rd_ptr_q] : '0;
        bus.instruction_data_valid_out = head_valid && fifo_pc_valid_q[rd_ptr_q] &&
                                         !fifo_fault_q[rd_ptr_q];
        bus.instruction_fault_out      = head_valid && fifo_fault_q[rd_ptr_q];
        dbg_state                      = state_q;
        dbg_count                      = count_q;
    end
endmodule

// File: tb/tb_fetch_buffer_stage.sv
// Directed bench for fetch_buffer_stage with a small instruction-memory responder and
// an expected-PC queue for ordering checks.
module tb_fetch_buffer_stage;
    localparam int AW    = 32;
    localparam int IW    = 32;
    localparam int DEPTH = 2;
    localparam int CW    = $clog2(DEPTH + 1);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fetch_buffer_stage_if #(.ADDR_WIDTH(AW), .INSTRUCTION_WIDTH(IW)) bus ();
    logic [1:0]    dbg_state;
    logic [CW-1:0] dbg_count;

    fetch_buffer_stage #(.ADDR_WIDTH(AW), .INSTRUCTION_WIDTH(IW), .BUF_DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state),
        .dbg_count (dbg_count)
    );

    int            n_checks = 0;
    int            n_fail   = 0;
    int            mem_lat  = 0;
    bit            mem_hold = 1'b0;
    logic [AW-1:0] err_addr = '1;
    int            mem_wait = 0;
    int            fetch_cnt = 0;
    logic [AW-1:0] exp_q[$];

    function automatic logic [IW-1:0] mem_word(input logic [AW-1:0] a);
        if (a == 32'h100) return 32'hDEADBEEF;
        return 32'hC0DE_0000 | {16'h0, a[15:0]};
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [AW-1:0] pc, input logic v);
        bus.prev_done              = 1'b1;
        bus.program_count_in       = pc;
        bus.program_count_valid_in = v;
    endtask

    task automatic wait_head(input int budget, output int n);
        n = 0;
        while (!bus.done_next && n < budget) begin
            tick();
            @(negedge clk);
            n++;
        end
    endtask

    // Instruction memory: answers an active request after mem_lat idle cycles.
    initial begin
        bus.instruction_fetch_done  = 1'b0;
        bus.instruction_data        = '0;
        bus.instruction_fetch_error = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (bus.instruction_fetch_activate && !mem_hold) begin
                if (mem_wait >= mem_lat) begin
                    bus.instruction_fetch_done  = 1'b1;
                    bus.instruction_data        = mem_word(bus.instruction_addr);
                    bus.instruction_fetch_error = (bus.instruction_addr == err_addr);
                    mem_wait = 0;
                    fetch_cnt++;
                end else begin
                    bus.instruction_fetch_done = 1'b0;
                    mem_wait++;
                end
            end else begin
                bus.instruction_fetch_done = 1'b0;
                if (!bus.instruction_fetch_activate) mem_wait = 0;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int            n;
        int            f0;
        int            k;
        int            got;
        int            first_pop;
        int            last_pop;
        bit            acc;
        logic [AW-1:0] exp_pc;
        logic [AW-1:0] pcs[8];

        rst                        = 1'b1;
        bus.flush                  = 1'b0;
        bus.prev_done              = 1'b0;
        bus.next_stall             = 1'b0;
        bus.program_count_in       = '0;
        bus.program_count_valid_in = 1'b0;

        // Reset state
        repeat (3) tick();
        @(negedge clk);
        check_eq("rst_stall_prev", bus.stall_prev, 1);
        check_eq("rst_done_next", bus.done_next, 0);
        check_eq("rst_activate", bus.instruction_fetch_activate, 0);
        check_eq("rst_pc_out", bus.program_count_out, 0);
        check_eq("rst_state", dbg_state, 0);
        check_eq("rst_count", dbg_count, 0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check_eq("post_rst_ready", bus.stall_prev, 0);

        // Single fetch of 0x100
        mem_lat = 2;
        f0 = fetch_cnt;
        tick();
        offer(32'h100, 1'b1);
        @(negedge clk);
        check_eq("t1_stall_prev", bus.stall_prev, 0);
        tick();
        bus.prev_done = 1'b0;
        @(negedge clk);
        check_eq("t1_activate", bus.instruction_fetch_activate, 1);
        check_eq("t1_addr", bus.instruction_addr, 32'h100);
        wait_head(20, n);
        check_eq("t1_latency", n, 3);
        check_eq("t1_pc_out", bus.program_count_out, 32'h100);
        check_eq("t1_pc_valid", bus.program_count_valid_out, 1);
        check_eq("t1_instr", bus.instruction_data_out, 32'hDEADBEEF);
        check_eq("t1_instr_valid", bus.instruction_data_valid_out, 1);
        check_eq("t1_fault", bus.instruction_fault_out, 0);
        check_eq("t1_idle_after", bus.instruction_fetch_activate, 0);
        check_eq("t1_fetches", fetch_cnt - f0, 1);
        tick();
        @(negedge clk);
        check_eq("t1_popped", bus.done_next, 0);

        // Invalid-PC bubble
        f0 = fetch_cnt;
        tick();
        offer(32'h40, 1'b0);
        tick();
        bus.prev_done = 1'b0;
        @(negedge clk);
        check_eq("t2_done_next", bus.done_next, 1);
        check_eq("t2_pc_out", bus.program_count_out, 32'h40);
        check_eq("t2_pc_valid", bus.program_count_valid_out, 0);
        check_eq("t2_instr", bus.instruction_data_out, 0);
        check_eq("t2_instr_valid", bus.instruction_data_valid_out, 0);
        check_eq("t2_fault", bus.instruction_fault_out, 0);
        check_eq("t2_activate", bus.instruction_fetch_activate, 0);
        tick();
        @(negedge clk);
        check_eq("t2_popped", bus.done_next, 0);
        check_eq("t2_no_fetch", fetch_cnt - f0, 0);

        // Faulting fetch
        mem_lat  = 0;
        err_addr = 32'h200;
        tick();
        offer(32'h200, 1'b1);
        tick();
        bus.prev_done = 1'b0;
        @(negedge clk);
        wait_head(10, n);
        check_eq("t3_latency", n, 1);
        check_eq("t3_pc_out", bus.program_count_out, 32'h200);
        check_eq("t3_pc_valid", bus.program_count_valid_out, 1);
        check_eq("t3_instr", bus.instruction_data_out, 0);
        check_eq("t3_instr_valid", bus.instruction_data_valid_out, 0);
        check_eq("t3_fault", bus.instruction_fault_out, 1);
        tick();
        err_addr = '1;

        // Downstream stall with four PCs offered
        pcs[0] = 32'h0; pcs[1] = 32'h4; pcs[2] = 32'h8; pcs[3] = 32'hC;
        bus.next_stall = 1'b1;
        f0 = fetch_cnt;
        k  = 0;
        offer(pcs[0], 1'b1);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            acc = bus.prev_done && !bus.stall_prev;
            tick();
            if (acc) begin
                exp_q.push_back(pcs[k]);
                k++;
                if (k < 4) bus.program_count_in = pcs[k];
                else bus.prev_done = 1'b0;
            end
        end
        @(negedge clk);
        check_eq("t4_accepted", k, 2);
        check_eq("t4_stall_prev", bus.stall_prev, 1);
        check_eq("t4_count", dbg_count, 2);
        check_eq("t4_state", dbg_state, 0);
        check_eq("t4_done_next", bus.done_next, 1);
        check_eq("t4_head_pc", bus.program_count_out, 32'h0);
        check_eq("t4_activate", bus.instruction_fetch_activate, 0);
        check_eq("t4_fetches_stalled", fetch_cnt - f0, 2);
        tick();
        bus.next_stall = 1'b0;
        got = 0;
        for (int c = 0; c < 40 && got < 4; c++) begin
            @(negedge clk);
            acc = bus.prev_done && !bus.stall_prev;
            if (bus.done_next && !bus.next_stall) begin
                exp_pc = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
                check_eq("t4_out_pc", bus.program_count_out, exp_pc);
                check_eq("t4_out_instr", bus.instruction_data_out, mem_word(exp_pc));
                got++;
            end
            tick();
            if (acc) begin
                exp_q.push_back(pcs[k]);
                k++;
                if (k < 4) bus.program_count_in = pcs[k];
                else bus.prev_done = 1'b0;
            end
        end
        check_eq("t4_out_count", got, 4);
        check_eq("t4_queue_left", exp_q.size(), 0);
        check_eq("t4_fetches_total", fetch_cnt - f0, 4);

        // Flush while REQ with one queued entry
        bus.next_stall = 1'b1;
        mem_hold       = 1'b1;
        tick();
        offer(32'h50, 1'b0);
        tick();
        offer(32'h300, 1'b1);
        tick();
        bus.prev_done = 1'b0;
        @(negedge clk);
        check_eq("t5_count_before", dbg_count, 1);
        check_eq("t5_state_req", dbg_state, 1);
        check_eq("t5_addr", bus.instruction_addr, 32'h300);
        tick();
        bus.flush = 1'b1;
        @(negedge clk);
        check_eq("t5_flush_done_next", bus.done_next, 0);
        check_eq("t5_flush_stall", bus.stall_prev, 1);
        tick();
        bus.flush = 1'b0;
        @(negedge clk);
        check_eq("t5_state_drain", dbg_state, 2);
        check_eq("t5_count_zero", dbg_count, 0);
        check_eq("t5_drain_activate", bus.instruction_fetch_activate, 1);
        check_eq("t5_drain_addr", bus.instruction_addr, 32'h300);
        check_eq("t5_drain_stall", bus.stall_prev, 1);
        check_eq("t5_drain_done_next", bus.done_next, 0);
        f0 = fetch_cnt;
        tick();
        mem_hold = 1'b0;
        mem_lat  = 0;
        @(negedge clk);
        check_eq("t5_drain_resp_stall", bus.stall_prev, 1);
        tick();
        @(negedge clk);
        check_eq("t5_state_idle", dbg_state, 0);
        check_eq("t5_activate_off", bus.instruction_fetch_activate, 0);
        check_eq("t5_dropped", bus.done_next, 0);
        check_eq("t5_count_after", dbg_count, 0);
        check_eq("t5_one_resp", fetch_cnt - f0, 1);
        bus.next_stall = 1'b0;

        // Flush in the same cycle as the response
        mem_lat = 1;
        tick();
        offer(32'h310, 1'b1);
        tick();
        bus.prev_done = 1'b0;
        tick();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        @(negedge clk);
        check_eq("t6_state", dbg_state, 0);
        check_eq("t6_count", dbg_count, 0);
        check_eq("t6_done_next", bus.done_next, 0);
        check_eq("t6_activate", bus.instruction_fetch_activate, 0);
        tick();
        @(negedge clk);
        check_eq("t6_nothing_pushed", bus.done_next, 0);

        // Continuous streaming: one instruction per cycle
        mem_lat = 0;
        for (int i = 0; i < 8; i++) pcs[i] = 32'h1000 + 32'(4 * i);
        k = 0; got = 0; first_pop = -1; last_pop = -1;
        tick();
        offer(pcs[0], 1'b1);
        for (int c = 0; c < 40 && got < 8; c++) begin
            @(negedge clk);
            acc = bus.prev_done && !bus.stall_prev;
            if (bus.done_next && !bus.next_stall) begin
                exp_pc = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
                check_eq("t7_out_pc", bus.program_count_out, exp_pc);
                if (first_pop < 0) first_pop = c;
                last_pop = c;
                got++;
            end
            tick();
            if (acc) begin
                exp_q.push_back(pcs[k]);
                k++;
                if (k < 8) bus.program_count_in = pcs[k];
                else bus.prev_done = 1'b0;
            end
        end
        check_eq("t7_out_count", got, 8);
        check_eq("t7_back_to_back", last_pop - first_pop, 7);
        check_eq("t7_queue_left", exp_q.size(), 0);

        // Reset while a fetch is outstanding
        mem_hold = 1'b1;
        tick();
        offer(32'h400, 1'b1);
        tick();
        bus.prev_done = 1'b0;
        @(negedge clk);
        check_eq("t8_activate_req", bus.instruction_fetch_activate, 1);
        tick();
        rst = 1'b1;
        @(negedge clk);
        check_eq("t8_rst_activate", bus.instruction_fetch_activate, 0);
        check_eq("t8_rst_done_next", bus.done_next, 0);
        check_eq("t8_rst_stall", bus.stall_prev, 1);
        tick();
        @(negedge clk);
        check_eq("t8_rst_state", dbg_state, 0);
        tick();
        rst      = 1'b0;
        mem_hold = 1'b0;
        @(negedge clk);
        check_eq("t8_after_activate", bus.instruction_fetch_activate, 0);
        check_eq("t8_after_ready", bus.stall_prev, 0);
        check_eq("t8_after_done_next", bus.done_next, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
